// File: rtl/seq_divider_param_if.sv
// Request/response bundle for the sequential divider: operands and start in,
// quotient, remainder, handshake and flags out.
interface seq_divider_param_if #(
    parameter int N = 8
);
    logic             start;
    logic [N-1:0]     A;
    logic [2*N-1:0]   B;
    logic [N-1:0]     Q;
    logic [N-1:0]     R;
    logic             busy;
    logic             Done;
    logic             dz;
    logic             ovf;

    modport master (
        output start, A, B,
        input  Q, R, busy, Done, dz, ovf
    );

    modport slave (
        input  start, A, B,
        output Q, R, busy, Done, dz, ovf
    );
endinterface

// File: rtl/seq_divider_param.sv
// Restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock,
// with start/busy/done handshake and divide-by-zero / overflow detection.
module seq_divider_param #(
    parameter int N = 8
) (
    input logic                clk,
    input logic                clear,
    seq_divider_param_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_pend;
    logic [CW-1:0]    r_cnt;
    logic [N-1:0]     r_a;
    logic [2*N-1:0]   r_b;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_lo;
    logic [N-1:0]     r_quo;
    logic [N-1:0]     r_q;
    logic [N-1:0]     r_r;
    logic             r_dz;
    logic             r_ovf;

    logic             w_accept;
    logic             w_a_zero;
    logic             w_hi_ovf;
    logic             w_flagged;
    logic [N:0]       w_t;
    logic             w_ge;
    logic [N-1:0]     w_diff;
    logic [N-1:0]     w_rem_nxt;
    logic             w_last;

    // Operands are latched on the accepting edge and classified one cycle later
    // (r_pend), so every path sees registered operands only.
    assign w_accept  = bus.start && !r_pend && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_a_zero  = (r_a == '0);
    assign w_hi_ovf  = (r_b[2*N-1:N] >= r_a);
    assign w_flagged = w_a_zero || w_hi_ovf;

    // One restoring step; the difference fits in N bits whenever it is taken.
    assign w_t       = {r_rem, r_lo[N-1]};
    assign w_ge      = (w_t >= {1'b0, r_a});
    assign w_diff    = w_t[N-1:0] - r_a;
    assign w_rem_nxt = w_ge ? w_diff : w_t[N-1:0];
    assign w_last    = (r_cnt == CW'(N - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (r_pend) begin
                    w_next = w_flagged ? S_DONE : S_DIV;
                end else if (w_accept) begin
                    w_next = S_IDLE;
                end
            end
            S_DIV: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pend  <= w_accept;
            r_cnt   <= (r_state == S_DIV) ? r_cnt + CW'(1) : '0;
            if (w_accept) begin
                r_dz  <= 1'b0;
                r_ovf <= 1'b0;
            end else if (r_pend) begin
                r_dz  <= w_a_zero;
                r_ovf <= !w_a_zero && w_hi_ovf;
            end
            // Results only change on entry to DONE.
            if (r_pend && w_flagged) begin
                r_q <= w_a_zero ? '0 : '1;
                r_r <= r_b[N-1:0];
            end else if ((r_state == S_DIV) && w_last) begin
                r_q <= {r_quo[N-2:0], w_ge};
                r_r <= w_rem_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= bus.A;
            r_b <= bus.B;
        end
        if (r_pend) begin
            r_rem <= r_b[2*N-1:N];
            r_lo  <= r_b[N-1:0];
            r_quo <= '0;
        end else if (r_state == S_DIV) begin
            r_rem <= w_rem_nxt;
            r_lo  <= {r_lo[N-2:0], 1'b0};
            r_quo <= {r_quo[N-2:0], w_ge};
        end
    end

    assign bus.Q    = r_q;
    assign bus.R    = r_r;
    assign bus.busy = (r_state == S_DIV);
    assign bus.Done = (r_state == S_DONE);
    assign bus.dz   = r_dz;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_seq_divider_param.sv
// Bench for seq_divider_param: directed vector table at N=8/N=16, handshake and
// clear sequences, and randomized operands against an arithmetic reference.
module tb_seq_divider_param;
  logic clk;
  logic clear;
  int   total;
  int   bad;

  seq_divider_param_if #(.N(8))  b8();
  seq_divider_param_if #(.N(16)) b16();

  seq_divider_param #(.N(8))  u8  (.clk(clk), .clear(clear), .bus(b8));
  seq_divider_param #(.N(16)) u16 (.clk(clk), .clear(clear), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int n, input logic st, input logic [31:0] a, input logic [31:0] b);
    if (n == 8) begin
      b8.start = st; b8.A = a[7:0]; b8.B = b[15:0];
    end else begin
      b16.start = st; b16.A = a[15:0]; b16.B = b;
    end
  endtask

  task automatic sample(input int n, output logic [15:0] q, output logic [15:0] r,
                        output logic bs, output logic dn, output logic z, output logic o);
    if (n == 8) begin
      q = {8'h00, b8.Q}; r = {8'h00, b8.R};
      bs = b8.busy; dn = b8.Done; z = b8.dz; o = b8.ovf;
    end else begin
      q = b16.Q; r = b16.R;
      bs = b16.busy; dn = b16.Done; z = b16.dz; o = b16.ovf;
    end
  endtask

  // Reference: plain integer division with the flag rules applied on top.
  task automatic model(input int n, input longint unsigned a, input longint unsigned b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic z, output logic o, output int lat);
    longint unsigned lim;
    longint unsigned lo;
    lim = 64'd1 << n;
    lo  = b % lim;
    z = 1'b0; o = 1'b0;
    if (a == 0) begin
      z = 1'b1; q = 16'd0; r = lo[15:0]; lat = 1;
    end else if (b / a >= lim) begin
      o = 1'b1; q = 16'((lim - 1)); r = lo[15:0]; lat = 1;
    end else begin
      q = 16'(b / a); r = 16'(b % a); lat = n + 1;
    end
  endtask

  // Runs one operation; inj>=0 pulses start again after that many cycles.
  task automatic op(input int n, input logic [31:0] a, input logic [31:0] b, input int inj,
                    output logic [15:0] q, output logic [15:0] r,
                    output logic z, output logic o, output int lat, output int bcnt);
    logic [15:0] q0, r0;
    logic bs, dn;
    bit   stable;
    sample(n, q0, r0, bs, dn, z, o);
    @(negedge clk);
    drive(n, 1'b1, a, b);
    @(posedge clk);
    #1;
    drive(n, 1'b0, $urandom, $urandom);
    sample(n, q, r, bs, dn, z, o);
    chk("accept_clears_done_flags", {bs, dn, z, o}, 4'b0000);
    lat = 0; bcnt = 0; stable = 1'b1;
    while (!dn && lat < 40) begin
      @(negedge clk);
      drive(n, (lat == inj), $urandom, $urandom);
      @(posedge clk);
      #1;
      lat++;
      sample(n, q, r, bs, dn, z, o);
      if (bs) bcnt++;
      if (!dn && (q !== q0 || r !== r0)) stable = 1'b0;
    end
    drive(n, 1'b0, 32'd0, 32'd0);
    chk("done_within_bound", dn, 1'b1);
    chk("qr_hold_while_busy", stable, 1'b1);
  endtask

  initial begin
    vec_t        vt[$];
    logic [15:0] q, r, mq, mr, hq, hr;
    logic        z, o, mz, mo, bs, dn, hz, ho;
    int          lat, bcnt, mlat;
    logic [31:0] a, b;
    longint unsigned la, lb;

    total = 0; bad = 0;
    vt.push_back('{8,  32'd3,    32'd10,         16'h0003, 16'h0001, 1'b0, 1'b0, 9});
    vt.push_back('{8,  32'd7,    32'd100,        16'd14,   16'd2,    1'b0, 1'b0, 9});
    vt.push_back('{8,  32'd0,    32'h000B,       16'h0000, 16'h000B, 1'b1, 1'b0, 1});
    vt.push_back('{8,  32'd3,    32'h0300,       16'h00FF, 16'h0000, 1'b0, 1'b1, 1});
    vt.push_back('{8,  32'hFF,   32'hFEFF,       16'h00FF, 16'h00FE, 1'b0, 1'b0, 9});
    vt.push_back('{8,  32'd1,    32'h00FF,       16'h00FF, 16'h0000, 1'b0, 1'b0, 9});
    vt.push_back('{8,  32'd2,    32'h01FF,       16'h00FF, 16'h0001, 1'b0, 1'b0, 9});
    vt.push_back('{8,  32'd1,    32'h0100,       16'h00FF, 16'h0000, 1'b0, 1'b1, 1});
    vt.push_back('{8,  32'd0,    32'hFFFF,       16'h0000, 16'h00FF, 1'b1, 1'b0, 1});
    vt.push_back('{8,  32'd9,    32'd0,          16'h0000, 16'h0000, 1'b0, 1'b0, 9});
    vt.push_back('{16, 32'd7,    32'd100000,     16'd14285, 16'd5,   1'b0, 1'b0, 17});
    vt.push_back('{16, 32'd0,    32'h12345678,   16'h0000, 16'h5678, 1'b1, 1'b0, 1});
    vt.push_back('{16, 32'h1234, 32'h12340000,   16'hFFFF, 16'h0000, 1'b0, 1'b1, 1});
    vt.push_back('{16, 32'hFFFF, 32'hFFFEFFFF,   16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 17});

    clear = 1'b1;
    drive(8, 1'b0, 32'd0, 32'd0);
    drive(16, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    sample(8, q, r, bs, dn, z, o);
    chk("reset8", {q, r, bs, dn, z, o}, 36'd0);
    sample(16, q, r, bs, dn, z, o);
    chk("reset16", {q, r, bs, dn, z, o}, 36'd0);
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sample(8, q, r, bs, dn, z, o);
    chk("idle_after_reset", {q, r, bs, dn, z, o}, 36'd0);

    foreach (vt[i]) begin
      op(vt[i].n, vt[i].a, vt[i].b, -1, q, r, z, o, lat, bcnt);
      chk($sformatf("vec%0d_q", i), q, vt[i].q);
      chk($sformatf("vec%0d_r", i), r, vt[i].r);
      chk($sformatf("vec%0d_flags", i), {z, o}, {vt[i].z, vt[i].o});
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, (vt[i].lat == 1) ? 0 : vt[i].n);
    end

    // Results hold in DONE with start low.
    repeat (3) @(posedge clk);
    #1;
    sample(16, hq, hr, bs, dn, hz, ho);
    chk("done_hold", {hq, hr, bs, dn, hz, ho}, {16'hFFFF, 16'hFFFE, 4'b0100});

    // Start pulsed mid-DIV must be ignored.
    op(8, 32'd3, 32'd10, 3, q, r, z, o, lat, bcnt);
    chk("ignore_start_in_div", {q, r, z, o}, {16'd3, 16'd1, 2'b00});
    chk("ignore_start_latency", lat, 9);
    repeat (3) @(posedge clk);
    #1;
    sample(8, q, r, bs, dn, z, o);
    chk("no_restart_after_ignored", {q, r, bs, dn}, {16'd3, 16'd1, 2'b01});

    // Clear in the middle of an operation aborts it immediately.
    @(negedge clk);
    drive(8, 1'b1, 32'd3, 32'd10);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 32'd0, 32'd0);
    repeat (4) @(posedge clk);
    #3;
    sample(8, q, r, bs, dn, z, o);
    chk("busy_before_clear", bs, 1'b1);
    clear = 1'b1;
    #1;
    sample(8, q, r, bs, dn, z, o);
    chk("async_clear_mid_div", {q, r, bs, dn, z, o}, 36'd0);
    @(negedge clk);
    clear = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    sample(8, q, r, bs, dn, z, o);
    chk("no_stale_after_clear", {q, r, bs, dn, z, o}, 36'd0);
    op(8, 32'd7, 32'd100, -1, q, r, z, o, lat, bcnt);
    chk("recover_after_clear", {q, r, z, o}, {16'd14, 16'd2, 2'b00});

    for (int k = 0; k < 1300; k++) begin
      int n;
      int mode;
      n = (k < 300) ? 8 : 16;
      mode = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      if (n == 8) begin
        a = a & 32'hFF; b = b & 32'hFFFF;
      end else begin
        a = a & 32'hFFFF;
      end
      if (mode == 0) a = 32'd0;
      else if (mode >= 2 && a != 0) b = (n == 8) ? {16'd0, 8'($urandom % a), b[7:0]}
                                                 : {16'($urandom % a), b[15:0]};
      la = a; lb = b;
      model(n, la, lb, mq, mr, mz, mo, mlat);
      op(n, a, b, -1, q, r, z, o, lat, bcnt);
      chk($sformatf("rand%0d_n%0d_a%0h_b%0h", k, n, a, b), {q, r, z, o}, {mq, mr, mz, mo});
      chk($sformatf("rand%0d_latency", k), lat, mlat);
      if (!mz && !mo)
        chk($sformatf("rand%0d_invariant", k),
            ((longint'(q) * la + longint'(r)) == lb) && (longint'(r) < la), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Parametrised sequential restoring divider: 2N-bit dividend divided by N-bit divisor.
- Produces an N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Successor to the fixed 8-bit/16-bit divider top level. Adds a start/busy/done handshake, width parametrisation, and explicit divide-by-zero and overflow flags.
- Sits in the datapath as a shared arithmetic unit; the requester holds operands only for the start cycle.

Parameters:
- N, 8, divisor/quotient/remainder width; dividend width is 2N; legal N >= 2.

Ports:
- clk  in  1  rising-edge clock
- clear  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- A  in  N  divisor; captured on accepted start
- B  in  2N  dividend; captured on accepted start
- Q  out  N  quotient
- R  out  N  remainder
- busy  out  1  high while iterating
- Done  out  1  level; result valid
- dz  out  1  divide-by-zero flag, valid with Done
- ovf  out  1  quotient-overflow flag, valid with Done

Behaviour:
- Reset (clear=1, async, any state):
  - state=IDLE, Q=0, R=0, busy=0, Done=0, dz=0, ovf=0, iteration counter=0.
  - A reset mid-operation aborts the operation; no stale result survives.
- States: IDLE, DIV, DONE.
- Accepted start: start=1 at a rising edge while in IDLE or DONE.
  - Latches A and B, clears Done/dz/ovf in the same edge, then classifies the operation.
- Divide by zero (A==0):
  - Next state DONE; Done=1 at the accepting edge+1 (one cycle after acceptance).
  - dz=1, Q=0, R=B[N-1:0] (same as the predecessor block).
- Overflow (A!=0 and B[2N-1:N] >= A):
  - DONE one cycle after acceptance.
  - ovf=1, Q=all ones, R=B[N-1:0].
- Normal (no dz, no ovf):
  - Go to DIV with busy=1.
  - Partial remainder (N+1 bits) initialised to B[2N-1:N].
  - Dividend low half shifts in MSB first.
  - Each DIV cycle: t={rem[N-1:0], next bit}. If t >= A then rem=t-A and qbit=1, else rem=t and qbit=0. qbit shifts into the quotient LSB.
  - Exactly N DIV cycles, then DONE.
  - Done rises at the accepting edge + N + 1; busy falls at the same edge.
  - Q=quotient, R=rem[N-1:0]. The invariant B == Q*A + R with R < A always holds.
- DONE:
  - Q, R, dz, ovf and Done hold until the next accepted start or clear.
  - A start in DONE is accepted exactly as in IDLE (back-to-back operation, no idle cycle needed).
- Start while in DIV (busy=1) is ignored; the operand inputs are don't-care after acceptance.
- Q and R update only on the transition into DONE. They are never partial or glitching while busy.
- Flags: dz and ovf are mutually exclusive; both are 0 for a normal result.
- All arithmetic is unsigned.

Test Plan:
- Basic, N=8: A=3, B=10, pulse start → busy for 8 cycles, Done at start edge+9, Q=0x03, R=0x01, dz=0, ovf=0.
- Divide by zero: A=0, B=0x000B → Done one cycle after start, dz=1, Q=0x00, R=0x0B, busy never asserted.
- Overflow: A=3, B=0x0300 → Done one cycle after start, ovf=1, Q=0xFF, R=0x00.
- Max legal operands: A=0xFF, B=0xFEFF → Q=0xFF, R=0xFE, no flags.
- Handshake and reset: second start asserted mid-DIV is ignored (first result 10/3 unchanged). A new start in DONE with A=7, B=100 gives Q=14, R=2. Asserting clear at DIV cycle 4 immediately zeroes all outputs and returns to IDLE.
- N=16 instance: A=7, B=100000 → Done at start edge+17, Q=14285, R=5; random sweep of 1000 operands checks B==Q*A+R and R<A.
